db_read_addr_gen: RTL

//  Read-side address generator for one double-buffer bank of memory_core. After start, walks an up-to-6-D

---
 rtl/db_agen_pkg.sv | 17 +
 rtl/db_agen_dim_cnt.sv | 65 ++++++
 rtl/db_read_addr_gen.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/db_agen_pkg.sv
// Shared types and default sizing for the double-buffer read address generator.
package db_agen_pkg;

  localparam int unsigned DB_NUM_DIMS = 6;
  localparam int unsigned DB_ADDR_W   = 16;
  localparam int unsigned DB_RANGE_W  = 32;
  localparam int unsigned DB_CNT_W    = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef logic [2:0] dim_idx_t;

endpackage

// File: rtl/db_agen_dim_cnt.sv
// One loop dimension: index counter with wrap/carry and the address rewind offset
// applied when a carry lands in this dimension.
module db_agen_dim_cnt
  import db_agen_pkg::*;
#(
  parameter int unsigned ADDR_W  = DB_ADDR_W,
  parameter int unsigned RANGE_W = DB_RANGE_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               advance,
  input  logic               active_in,
  input  logic [RANGE_W-1:0] range_in,
  input  logic [ADDR_W-1:0]  stride_in,
  input  logic [ADDR_W-1:0]  span_below_in,
  input  logic               carry_in,
  output logic               carry_out,
  output logic [ADDR_W-1:0]  span_out,
  output logic [ADDR_W-1:0]  rewind_out
);

  logic [RANGE_W-1:0] idx_q, idx_d;
  logic [RANGE_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0]  rewind_q, rewind_d;
  logic [RANGE_W-1:0] eff_last;

  // Inactive dims and range 0/1 both collapse to a single iteration.
  always_comb begin
    eff_last = '0;
    if (active_in && (range_in != '0)) begin
      eff_last = range_in - RANGE_W'(1);
    end
  end

  assign span_out   = eff_last[ADDR_W-1:0] * stride_in;
  assign carry_out  = carry_in & (idx_q == last_q);
  assign rewind_out = rewind_q;

  always_comb begin
    idx_d    = idx_q;
    last_d   = last_q;
    rewind_d = rewind_q;
    if (load) begin
      idx_d    = '0;
      last_d   = eff_last;
      rewind_d = stride_in - span_below_in;
    end else if (advance && carry_in) begin
      idx_d = (idx_q == last_q) ? '0 : idx_q + RANGE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q    <= '0;
      last_q   <= '0;
      rewind_q <= '0;
    end else begin
      idx_q    <= idx_d;
      last_q   <= last_d;
      rewind_q <= rewind_d;
    end
  end

endmodule

// File: rtl/db_read_addr_gen.sv
// Read-side address generator for one double-buffer bank: walks a nested loop of up to
// NUM_DIMS dimensions from starting_addr and issues reads to the SRAM.
module db_read_addr_gen
  import db_agen_pkg::*;
#(
  parameter int unsigned NUM_DIMS = DB_NUM_DIMS,
  parameter int unsigned ADDR_W   = DB_ADDR_W,
  parameter int unsigned RANGE_W  = DB_RANGE_W,
  parameter int unsigned CNT_W    = DB_CNT_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clk_en,
  input  logic                         flush,
  input  logic                         start,
  input  logic                         rd_rdy,
  input  logic [3:0]                   dimensionality,
  input  logic [ADDR_W-1:0]            starting_addr,
  input  logic [NUM_DIMS*ADDR_W-1:0]   stride,
  input  logic [NUM_DIMS*RANGE_W-1:0]  range,
  input  logic [CNT_W-1:0]             iter_cnt,
  output logic                         ren_out,
  output logic [ADDR_W-1:0]            addr_out,
  output logic                         rd_valid_out,
  output logic                         busy,
  output logic                         done
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  iter_q, iter_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_valid_q, rd_valid_d;

  logic                            issue;
  logic                            load;
  logic [NUM_DIMS:0]               carry;
  logic [NUM_DIMS-1:0][ADDR_W-1:0] span;
  logic [NUM_DIMS-1:0][ADDR_W-1:0] span_below;
  logic [NUM_DIMS-1:0][ADDR_W-1:0] rewind;
  logic [ADDR_W-1:0]               span_acc;
  logic [ADDR_W-1:0]               step;
  logic [ADDR_W-1:0]               addr_next;

  assign issue = (state_q == ST_RUN) & rd_rdy & clk_en;
  assign load  = clk_en & ~flush & start & (state_q == ST_IDLE);

  assign carry[0] = 1'b1;

  for (genvar d = 0; d < NUM_DIMS; d++) begin : g_dim
    db_agen_dim_cnt #(
      .ADDR_W  (ADDR_W),
      .RANGE_W (RANGE_W)
    ) u_dim (
      .clk           (clk),
      .reset         (reset),
      .load          (load),
      .advance       (issue),
      .active_in     (dimensionality > 4'(d)),
      .range_in      (range[d*RANGE_W +: RANGE_W]),
      .stride_in     (stride[d*ADDR_W +: ADDR_W]),
      .span_below_in (span_below[d]),
      .carry_in      (carry[d]),
      .carry_out     (carry[d+1]),
      .span_out      (span[d]),
      .rewind_out    (rewind[d])
    );
  end

  always_comb begin
    span_acc   = '0;
    span_below = '0;
    for (int unsigned d = 0; d < NUM_DIMS; d++) begin
      span_below[d] = span_acc;
      span_acc      = span_acc + span[d];
    end
  end

  // Highest dimension reached by the carry picks the rewind offset; a carry out of
  // the top dimension means every active loop wrapped, so restart from the base.
  always_comb begin
    step = rewind[0];
    for (int unsigned d = 1; d < NUM_DIMS; d++) begin
      if (carry[d]) begin
        step = rewind[d];
      end
    end
    addr_next = carry[NUM_DIMS] ? base_q : addr_q + step;
  end

  always_comb begin
    state_d    = state_q;
    iter_d     = iter_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    addr_d     = addr_q;
    rd_valid_d = rd_valid_q;
    if (clk_en) begin
      rd_valid_d = issue;
      if (flush) begin
        state_d    = ST_IDLE;
        rd_valid_d = 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (start) begin
              iter_d  = iter_cnt;
              cnt_d   = '0;
              base_d  = starting_addr;
              addr_d  = starting_addr;
              state_d = (iter_cnt != '0) ? ST_RUN : ST_DRAIN;
            end
          end
          ST_RUN: begin
            if (issue) begin
              cnt_d  = cnt_q + CNT_W'(1);
              addr_d = addr_next;
              if (cnt_q + CNT_W'(1) == iter_q) begin
                state_d = ST_DRAIN;
              end
            end
          end
          ST_DRAIN: state_d = ST_IDLE;
          default:  state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      iter_q     <= '0;
      cnt_q      <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      iter_q     <= iter_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign ren_out      = issue;
  assign addr_out     = addr_q;
  assign rd_valid_out = rd_valid_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DRAIN) & clk_en;

endmodule
